// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - registered 4-bit binary adder with carry-in and carry-out
//
// Purpose: one arithmetic slice of the 16-bit datapath adder. The operands and
// carry-in are summed combinationally and the 5-bit result is captured in the
// output register on every rising clock edge, giving one cycle of latency and
// one operation per cycle.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset, clears S and C_out at once
//   A      in   4  operand A, unsigned
//   B      in   4  operand B, unsigned
//   C_in   in   1  carry-in
//   S      out  4  registered sum, (A + B + C_in) mod 16
//   C_out  out  1  registered carry-out, bit 4 of A + B + C_in
//
// Configuration macro: ADDER_4BIT_CLA_EN
//   defined   -> carry-lookahead core, every carry in two logic levels
//   undefined -> ripple-carry core of four chained full adders
// Both cores produce identical results at the ports.

module adder_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);

  logic [3:0] w_g;    // generate: this bit produces a carry on its own
  logic [3:0] w_p;    // propagate: this bit passes an incoming carry on
  logic [4:0] w_c;    // w_c[i] is the carry into bit i, w_c[4] the carry-out
  logic [3:0] w_s;

  logic [3:0] r_s;
  logic       r_c_out;

  assign w_g    = A & B;
  assign w_p    = A ^ B;
  assign w_c[0] = C_in;

`ifdef ADDER_4BIT_CLA_EN
  // Each carry is flattened into a sum of products over g, p and C_in so no
  // carry waits on its lower neighbour.
  assign w_c[1] = w_g[0]
                | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
`else
  // Full-adder carry per bit: c(i+1) = a&b | c&(a^b), chained bit to bit.
  for (genvar i = 0; i < 4; i++) begin : g_ripple
    assign w_c[i+1] = w_g[i] | (w_c[i] & w_p[i]);
  end
`endif

  assign w_s = w_p ^ w_c[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 4'h0;
      r_c_out <= 1'b0;
    end else begin
      r_s     <= w_s;
      r_c_out <= w_c[4];
    end
  end

  assign S     = r_s;
  assign C_out = r_c_out;

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - directed and sweep bench for adder_4bit

module tb_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       C_in;
  logic [3:0] S;
  logic       C_out;

  int checks;
  int errors;

  adder_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one vector between edges, then check the registered result just
  // after the edge that captures it.
  task automatic apply_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input logic ci, input logic [3:0] exp_s, input logic exp_co);
    @(negedge clk);
    A    = a;
    B    = b;
    C_in = ci;
    @(posedge clk);
    #1;
    check_val({tag, "_s"}, {4'h0, S}, {4'h0, exp_s});
    check_val({tag, "_co"}, {7'h0, C_out}, {7'h0, exp_co});
  endtask

  initial begin
    logic [4:0] sum;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    A      = 4'h0;
    B      = 4'h0;
    C_in   = 1'b0;

    #1;
    check_val("reset_s", {4'h0, S}, 8'h00);
    check_val("reset_co", {7'h0, C_out}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    // 7 + 8 + 1 = 16: S = 0, C_out = 1 before reset is applied
    apply_and_check("pre_rst", 4'h7, 4'h8, 1'b1, 4'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async_co", {7'h0, C_out}, 8'h00);
    check_val("rst_async_s", {4'h0, S}, 8'h00);
    @(posedge clk);
    #1;
    check_val("rst_hold_co", {7'h0, C_out}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rel_s", {4'h0, S}, 8'h00);
    check_val("rst_rel_co", {7'h0, C_out}, 8'h01);

    apply_and_check("cb_f01", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
    apply_and_check("cb_f00", 4'hF, 4'h0, 1'b0, 4'hF, 1'b0);
    apply_and_check("max",    4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    apply_and_check("b2b_0",  4'h3, 4'h4, 1'b0, 4'h7, 1'b0);
    apply_and_check("b2b_1",  4'h9, 4'h9, 1'b1, 4'h3, 1'b1);
    apply_and_check("mix_0",  4'hA, 4'h5, 1'b0, 4'hF, 1'b0);
    apply_and_check("mix_1",  4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
    apply_and_check("zero",   4'h0, 4'h0, 1'b0, 4'h0, 1'b0);

    // Exhaustive sweep with a mid-cycle reset pulse partway through.
    for (int i = 0; i < 512; i++) begin
      sum = {1'b0, 4'(i >> 5)} + {1'b0, 4'(i >> 1)} + {4'h0, 1'(i)};
      apply_and_check("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i), sum[3:0], sum[4]);
      if (i == 301) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_s", {4'h0, S}, 8'h00);
        check_val("mid_rst_co", {7'h0, C_out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
